// File: rtl/hls_run_pkg.sv
// ============================================================================
// hls_run_pkg : shared state, status and sizing definitions for the run sequencer | rev 1.0
// ============================================================================
`default_nettype none

package hls_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_READ  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [1:0] STATUS_IDLE   = 2'b00;
  localparam logic [1:0] STATUS_OK     = 2'b01;
  localparam logic [1:0] STATUS_RUN_TO = 2'b10;
  localparam logic [1:0] STATUS_MEM_TO = 2'b11;

  // Slave RAM port size field is in bits.
  localparam logic [6:0] BYTE_SIZE = 7'd8;

  function automatic state_t post_run_state(input logic [15:0] res_len);
    return (res_len != 16'd0) ? ST_READ : ST_DONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hls_slave_mem_port.sv
// ============================================================================
// hls_slave_mem_port : single-byte request engine on slave channel 0 with DataRdy timeout | rev 1.0
// ============================================================================
`default_nettype none

module hls_slave_mem_port
  import hls_run_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int MEM_LIMIT = 255
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              timeout_o,
  output logic [7:0]        rdata_o,
  output logic              oe_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [6:0]        size_o,
  input  logic              rdy_i,
  input  logic [7:0]        rdata_i
);

  localparam int CNT_W = $clog2(MEM_LIMIT + 1);

  logic              active_q, active_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // The cycle carrying DataRdy still shows the enables; they drop on the next edge.
  always_comb begin
    ack_o     = active_q & rdy_i;
    timeout_o = active_q & ~rdy_i & (cnt_q == CNT_W'(MEM_LIMIT - 1));
    active_d  = active_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    if (active_q) begin
      if (ack_o || timeout_o) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (req_i) begin
      active_d = 1'b1;
      we_d     = we_i;
      addr_d   = addr_i;
      wdata_d  = wdata_i;
      cnt_d    = '0;
    end
  end

  assign busy_o  = active_q;
  assign rdata_o = rdata_i;
  assign oe_o    = active_q & ~we_q;
  assign we_o    = active_q & we_q;
  assign addr_o  = active_q ? addr_q : '0;
  assign wdata_o = (active_q & we_q) ? {{(DATA_W-8){1'b0}}, wdata_q} : '0;
  assign size_o  = active_q ? BYTE_SIZE : 7'd0;

endmodule

`default_nettype wire

// File: rtl/hls_run_sequencer.sv
// ============================================================================
// hls_run_sequencer : preload / start / time / read-back controller for a Bambu accelerator top | rev 1.0
// ============================================================================
`default_nettype none

module hls_run_sequencer
  import hls_run_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int RUN_LIMIT = 200000000,
  parameter int MEM_LIMIT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         load_len,
  input  logic [ADDR_W-1:0]   res_addr,
  input  logic [15:0]         res_len,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [7:0]          ld_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [7:0]          rd_data,
  output logic                busy,
  output logic [1:0]          status,
  output logic [31:0]         cycles,
  output logic                start_port,
  input  logic                done_port,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [2*DATA_W-1:0] S_Wdata_ram,
  output logic [13:0]         S_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy
);

  state_t            state_q, state_d;
  logic [1:0]        status_q, status_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [15:0]       load_len_q, load_len_d;
  logic [15:0]       res_len_q, res_len_d;
  logic [15:0]       idx_q, idx_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic              mem_req, mem_we, mem_busy, mem_ack, mem_timeout;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              ch0_oe, ch0_we;
  logic [ADDR_W-1:0] ch0_addr;
  logic [DATA_W-1:0] ch0_wdata;
  logic [6:0]        ch0_size;

  hls_slave_mem_port #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LIMIT (MEM_LIMIT)
  ) u_mem_port (
    .clock_i   (clock),
    .reset_i   (reset),
    .req_i     (mem_req),
    .we_i      (mem_we),
    .addr_i    (mem_addr),
    .wdata_i   (ld_data),
    .busy_o    (mem_busy),
    .ack_o     (mem_ack),
    .timeout_o (mem_timeout),
    .rdata_o   (mem_rdata),
    .oe_o      (ch0_oe),
    .we_o      (ch0_we),
    .addr_o    (ch0_addr),
    .wdata_o   (ch0_wdata),
    .size_o    (ch0_size),
    .rdy_i     (Sout_DataRdy[0]),
    .rdata_i   (Sout_Rdata_ram[7:0])
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      status_q   <= STATUS_IDLE;
      cycles_q   <= '0;
      base_q     <= '0;
      res_addr_q <= '0;
      load_len_q <= '0;
      res_len_q  <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cycles_q   <= cycles_d;
      base_q     <= base_d;
      res_addr_q <= res_addr_d;
      load_len_q <= load_len_d;
      res_len_q  <= res_len_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    cycles_d   = cycles_q;
    base_d     = base_q;
    res_addr_d = res_addr_q;
    load_len_d = load_len_q;
    res_len_d  = res_len_q;
    idx_d      = idx_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    ld_ready   = (state_q == ST_LOAD) && !mem_busy && (idx_q < load_len_q);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (go) begin
          status_d   = STATUS_IDLE;
          cycles_d   = '0;
          base_d     = base_addr;
          res_addr_d = res_addr;
          load_len_d = load_len;
          res_len_d  = res_len;
          idx_d      = '0;
          state_d    = (load_len != 16'd0) ? ST_LOAD : ST_START;
        end
      end
      ST_LOAD: begin
        if (ld_valid && ld_ready) begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = base_q + ADDR_W'(idx_q);
          idx_d    = idx_q + 16'd1;
        end
        if (mem_timeout) begin
          state_d  = ST_ERR;
          status_d = STATUS_MEM_TO;
        end else if (mem_ack && (idx_q == load_len_q)) begin
          state_d = ST_START;
          idx_d   = '0;
        end
      end
      ST_START: begin
        cycles_d = 32'd1;
        if (done_port) begin
          state_d = post_run_state(res_len_q);
        end else if (RUN_LIMIT <= 1) begin
          state_d  = ST_ERR;
          status_d = STATUS_RUN_TO;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cycles_d = cycles_q + 32'd1;
        if (done_port) begin
          state_d = post_run_state(res_len_q);
        end else if (cycles_d == 32'(RUN_LIMIT)) begin
          state_d  = ST_ERR;
          status_d = STATUS_RUN_TO;
        end
      end
      ST_READ: begin
        // A new read is only issued once the previous byte has left on rd_*.
        if (!mem_busy && !rd_valid_q && (idx_q < res_len_q)) begin
          mem_req  = 1'b1;
          mem_addr = res_addr_q + ADDR_W'(idx_q);
        end
        if (mem_ack) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rdata;
          idx_d      = idx_q + 16'd1;
        end
        if (mem_timeout) begin
          state_d  = ST_ERR;
          status_d = STATUS_MEM_TO;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          if (idx_q == res_len_q) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) status_d = STATUS_OK;
  end

  assign busy            = (state_q == ST_LOAD) || (state_q == ST_START) ||
                           (state_q == ST_RUN)  || (state_q == ST_READ);
  assign start_port      = (state_q == ST_START);
  assign status          = status_q;
  assign cycles          = cycles_q;
  assign rd_valid        = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign S_oe_ram        = {1'b0, ch0_oe};
  assign S_we_ram        = {1'b0, ch0_we};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, ch0_addr};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, ch0_wdata};
  assign S_data_ram_size = {7'd0, ch0_size};

endmodule

`default_nettype wire
